// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit engine: one-deep byte hold, LSB-first shifter,
// bit stuffing after six ones, NRZI onto D+/D-, and EOP (SE0, SE0, J) at packet end.
module usb_tx_encoder #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       d_plus,
    output logic       d_minus,
    output logic       transmitting,
    output logic       tx_underrun
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        EOP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [2:0]    ones;
    logic [7:0]    shifter;
    logic          shift_last;
    logic [7:0]    hold_data;
    logic          hold_last;
    logic          hold_full;
    logic [1:0]    eop_idx;
    logic          level;

    logic          period_end;
    logic          need_stuff;
    logic          byte_done;
    logic          take;
    logic          accept;
    logic          nxt_bit;
    logic [2:0]    ones_base;
    logic [2:0]    emit_ones;
    logic          emit_level;

    assign period_end = (cnt == LAST_CNT);
    assign need_stuff = (ones == 3'd6);
    assign byte_done  = (state == SEND) && period_end && !need_stuff && (bit_idx == 3'd7);
    assign take       = hold_full && ((state == IDLE) || (byte_done && !shift_last));
    assign tx_ready   = !hold_full && (state != EOP);
    assign accept     = tx_valid && tx_ready;

    // Next data bit to put on the line and its NRZI/ones-count effect.
    // The shifter is indexed by bit_idx rather than physically shifted.
    always_comb begin
        nxt_bit   = shifter[bit_idx + 3'd1];
        ones_base = ones;
        if (state != SEND) begin
            nxt_bit   = hold_data[0];
            ones_base = '0;
        end else if (bit_idx == 3'd7) begin
            nxt_bit = hold_data[0];
        end
        emit_ones  = nxt_bit ? (ones_base + 3'd1) : 3'd0;
        emit_level = nxt_bit ? level : ~level;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hold_data <= '0;
            hold_last <= 1'b0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_data <= tx_data;
            hold_last <= tx_last;
            hold_full <= 1'b1;
        end else if (take) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            ones         <= '0;
            shifter      <= '0;
            shift_last   <= 1'b0;
            eop_idx      <= '0;
            level        <= 1'b1;
            d_plus       <= 1'b1;
            d_minus      <= 1'b0;
            transmitting <= 1'b0;
            tx_underrun  <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    ones    <= '0;
                    level   <= 1'b1;
                    d_plus  <= 1'b1;
                    d_minus <= 1'b0;
                    if (hold_full) begin
                        state        <= SEND;
                        transmitting <= 1'b1;
                        shifter      <= hold_data;
                        shift_last   <= hold_last;
                        bit_idx      <= '0;
                        ones         <= emit_ones;
                        level        <= emit_level;
                        d_plus       <= emit_level;
                        d_minus      <= ~emit_level;
                    end
                end

                SEND: begin
                    cnt <= period_end ? '0 : cnt + CW'(1);
                    if (period_end) begin
                        if (need_stuff) begin
                            // Stuffed zero: toggle, clear count, data position unchanged.
                            ones    <= '0;
                            level   <= ~level;
                            d_plus  <= ~level;
                            d_minus <= level;
                        end else if (bit_idx != 3'd7) begin
                            bit_idx <= bit_idx + 3'd1;
                            ones    <= emit_ones;
                            level   <= emit_level;
                            d_plus  <= emit_level;
                            d_minus <= ~emit_level;
                        end else if (!shift_last && hold_full) begin
                            shifter    <= hold_data;
                            shift_last <= hold_last;
                            bit_idx    <= '0;
                            ones       <= emit_ones;
                            level      <= emit_level;
                            d_plus     <= emit_level;
                            d_minus    <= ~emit_level;
                        end else begin
                            state       <= EOP;
                            eop_idx     <= '0;
                            d_plus      <= 1'b0;
                            d_minus     <= 1'b0;
                            tx_underrun <= !shift_last;
                        end
                    end
                end

                EOP: begin
                    cnt <= period_end ? '0 : cnt + CW'(1);
                    if (period_end) begin
                        if (eop_idx == 2'd2) begin
                            state        <= IDLE;
                            transmitting <= 1'b0;
                        end else begin
                            eop_idx <= eop_idx + 2'd1;
                            if (eop_idx == 2'd1) begin
                                level   <= 1'b1;
                                d_plus  <= 1'b1;
                                d_minus <= 1'b0;
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Bench for usb_tx_encoder: a packet-level model (stuffing, NRZI, EOP) builds the
// expected per-clock line waveform, checked every cycle against the DUT.
module tb_usb_tx_encoder;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_ready;
    logic       d_plus;
    logic       d_minus;
    logic       transmitting;
    logic       tx_underrun;

    usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_last      (tx_last),
        .tx_ready     (tx_ready),
        .d_plus       (d_plus),
        .d_minus      (d_minus),
        .transmitting (transmitting),
        .tx_underrun  (tx_underrun)
    );

    always #5 clk = ~clk;

    // rdy: 0/1 = required tx_ready, 2 = not checked
    typedef struct packed {
        logic       dp;
        logic       dm;
        logic       tr;
        logic       und;
        logic [1:0] rdy;
    } sym_t;

    sym_t       exp_q[$];
    sym_t       model_q[$];
    logic [7:0] plan[$];
    bit         plan_under = 1'b0;
    bit         first_pending = 1'b0;
    bit         mon_en = 1'b0;
    int         tests = 0;
    int         fails = 0;
    int         busy_cnt = 0;
    int         trans_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Packet model: raw bit list with a zero after every six ones, then NRZI, then EOP.
    function automatic void build_model();
        int   ones;
        bit   line[$];
        bit   lvl;
        bit   v;
        sym_t s;
        model_q.delete();
        ones = 0;
        foreach (plan[i]) begin
            for (int b = 0; b < 8; b++) begin
                v = plan[i][b];
                line.push_back(v);
                if (v) ones++;
                else ones = 0;
                if (ones == 6) begin
                    line.push_back(1'b0);
                    ones = 0;
                end
            end
        end
        lvl = 1'b1;
        foreach (line[k]) begin
            if (!line[k]) lvl = !lvl;
            for (int c = 0; c < CPB; c++) begin
                s.dp = lvl; s.dm = !lvl; s.tr = 1'b1; s.und = 1'b0; s.rdy = 2'd2;
                model_q.push_back(s);
            end
        end
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < CPB; c++) begin
                s.dp = (p == 2); s.dm = 1'b0; s.tr = 1'b1;
                s.und = plan_under && (p == 0) && (c == 0);
                s.rdy = 2'd0;
                model_q.push_back(s);
            end
        end
    endfunction

    always @(negedge clk) begin : monitor
        sym_t e;
        if (mon_en) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else begin
                e.dp = 1'b1; e.dm = 1'b0; e.tr = 1'b0; e.und = 1'b0; e.rdy = 2'd1;
            end
            tests++;
            if (d_plus !== e.dp || d_minus !== e.dm || transmitting !== e.tr ||
                tx_underrun !== e.und || (e.rdy != 2'd2 && tx_ready !== e.rdy[0])) begin
                fails++;
                $display("FAIL line t=%0t: got dp=%b dm=%b tr=%b und=%b rdy=%b expected dp=%b dm=%b tr=%b und=%b rdy=%0d",
                         $time, d_plus, d_minus, transmitting, tx_underrun, tx_ready,
                         e.dp, e.dm, e.tr, e.und, e.rdy);
            end
            if (e.rdy == 2'd2 && !tx_ready) busy_cnt++;
            if (transmitting) trans_cnt++;
            if (first_pending && tx_valid && tx_ready) begin
                first_pending = 1'b0;
                build_model();
                e.dp = 1'b1; e.dm = 1'b0; e.tr = 1'b0; e.und = 1'b0; e.rdy = 2'd0;
                exp_q.push_back(e);
                foreach (model_q[i]) exp_q.push_back(model_q[i]);
            end
        end
    end

    task automatic offer(input logic [7:0] b, input logic last);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        tx_data  = b;
        tx_last  = last;
        tx_valid = 1'b1;
        while (!got && n < 2000) begin
            @(negedge clk);
            got = tx_ready;
            @(posedge clk);
            #1;
            n++;
        end
        tx_valid = 1'b0;
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL handshake: got no tx_ready in %0d cycles expected accept", n);
        end
    endtask

    task automatic send_packet(input bit under, input int gap);
        int n;
        plan_under    = under;
        first_pending = 1'b1;
        foreach (plan[i]) offer(plan[i], (i == plan.size() - 1) && !under);
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending symbols expected 0", exp_q.size());
        end
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [1:0] sync_lv [11];
    logic [1:0] ff_lv   [12];
    int         r;
    int         nb;

    initial begin
        // Pin the model against hand-derived line sequences (K=01, J=10, SE0=00).
        sync_lv = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10};
        plan = '{8'h80}; plan_under = 1'b0; build_model();
        check("model_sync_len", 32'(model_q.size()), 32'd88);
        for (int p = 0; p < 11; p++)
            check("model_sync_period", 32'({model_q[p*CPB].dp, model_q[p*CPB].dm}), 32'(sync_lv[p]));

        ff_lv = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10};
        plan = '{8'hFF}; build_model();
        check("model_ff_len", 32'(model_q.size()), 32'd96);
        for (int p = 0; p < 12; p++)
            check("model_ff_period", 32'({model_q[p*CPB].dp, model_q[p*CPB].dm}), 32'(ff_lv[p]));

        plan = '{8'hF0, 8'h03}; build_model();
        check("model_cross_len", 32'(model_q.size()), 32'd160);
        check("model_cross_p9", 32'({model_q[9*CPB].dp, model_q[9*CPB].dm}), 32'h2);
        check("model_cross_p10", 32'({model_q[10*CPB].dp, model_q[10*CPB].dm}), 32'h1);
        check("model_cross_p16", 32'({model_q[16*CPB].dp, model_q[16*CPB].dm}), 32'h1);

        // Reset state
        #12;
        check("rst_dp", 32'(d_plus), 32'd1);
        check("rst_dm", 32'(d_minus), 32'd0);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_trans", 32'(transmitting), 32'd0);
        check("rst_underrun", 32'(tx_underrun), 32'd0);
        @(negedge clk); #2 n_rst = 1'b1;
        @(posedge clk); #1 mon_en = 1'b1;
        repeat (10) begin @(posedge clk); #1; end

        // SYNC byte, transmitting window length
        trans_cnt = 0;
        plan = '{8'h80}; send_packet(1'b0, 3);
        check("sync_trans_cycles", 32'(trans_cnt), 32'd88);

        plan = '{8'hFF}; send_packet(1'b0, 2);
        plan = '{8'hF0, 8'h03}; send_packet(1'b0, 0);

        // Back-to-back with backpressure
        busy_cnt = 0;
        plan = '{8'h80, 8'hC3, 8'h5A}; send_packet(1'b0, 4);
        check("b2b_ready_drops", 32'(busy_cnt > 0), 32'd1);

        // Underrun
        plan = '{8'h80}; send_packet(1'b1, 5);

        // Asynchronous reset mid-SEND
        mon_en = 1'b0;
        offer(8'hFF, 1'b0);
        offer(8'h00, 1'b1);
        repeat (20) @(posedge clk);
        #3 n_rst = 1'b0;
        #1;
        check("midrst_dp", 32'(d_plus), 32'd1);
        check("midrst_dm", 32'(d_minus), 32'd0);
        check("midrst_ready", 32'(tx_ready), 32'd1);
        check("midrst_trans", 32'(transmitting), 32'd0);
        exp_q.delete();
        first_pending = 1'b0;
        @(negedge clk); #2 n_rst = 1'b1;
        @(posedge clk); #1 mon_en = 1'b1;
        repeat (40) begin @(posedge clk); #1; end

        // Randomized packets
        repeat (40) begin
            nb = $urandom_range(1, 4);
            plan.delete();
            for (int i = 0; i < nb; i++) begin
                r = $urandom_range(0, 3);
                if (r == 0) plan.push_back(8'hFF);
                else if (r == 1) plan.push_back(8'h80);
                else plan.push_back(8'($urandom));
            end
            send_packet($urandom_range(0, 4) == 0, $urandom_range(0, 6));
        end

        repeat (10) begin @(posedge clk); #1; end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
